rgb_fader: RTL and testbench

//   Upstream colour sequencer for the RGB PWM stage. Accepts target colours over a

---
 rtl/rgb_fader_pkg.sv | 11 +
 rtl/rgb_fader_chan.sv | 48 ++++
 rtl/rgb_fader.sv | 114 +++++++++++
 tb/tb_rgb_fader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fader_pkg.sv
// Shared definitions for the RGB colour fader and the PWM stage it drives.
package rgb_fader_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic {
        FADE_IDLE,
        FADE_RUN
    } fade_state_e;

endpackage

// File: rtl/rgb_fader_chan.sv
// One colour channel: holds a target and a current duty and moves the duty one
// LSB toward the target each time step is asserted.
module rgb_fader_chan
    import rgb_fader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] cmd_target,
    output logic [WIDTH-1:0] value,
    output logic             at_target
);

    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Move toward the target; never overshoots, so the +/-1 cannot wrap.
    always_comb begin
        value_d = value_q;
        if (value_q < target_q) begin
            value_d = value_q + WIDTH'(1);
        end else if (value_q > target_q) begin
            value_d = value_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= '0;
            value_q  <= '0;
        end else begin
            if (load) begin
                target_q <= cmd_target;
            end
            if (step) begin
                value_q <= value_d;
            end
        end
    end

    assign value     = value_q;
    assign at_target = (value_q == target_q);

endmodule

// File: rtl/rgb_fader.sv
// Colour sequencer: accepts target colours over valid/ready and ramps r/g/b
// toward them one LSB per step at a programmable step period.
module rgb_fader
    import rgb_fader_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_r,
    input  logic [WIDTH-1:0]  cmd_g,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [WIDTH-1:0]  r,
    output logic [WIDTH-1:0]  g,
    output logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done
);

    fade_state_e       state_q, state_d;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] presc_q, presc_d;
    logic              done_q, done_d;
    logic              accept;
    logic              step;
    logic              at_r, at_g, at_b;
    logic              all_at;

    assign accept = cmd_valid && (state_q == FADE_IDLE);
    assign all_at = at_r && at_g && at_b;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        step    = 1'b0;
        case (state_q)
            FADE_IDLE: begin
                if (cmd_valid) begin
                    state_d = FADE_RUN;
                    presc_d = '0;
                end
            end
            FADE_RUN: begin
                // Completion is checked before stepping, so done lands one clock after the last step.
                if (all_at) begin
                    state_d = FADE_IDLE;
                    done_d  = 1'b1;
                end else if (presc_q == rate_q) begin
                    presc_d = '0;
                    step    = 1'b1;
                end else begin
                    presc_d = presc_q + RATE_W'(1);
                end
            end
            default: state_d = FADE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FADE_IDLE;
            rate_q  <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            if (accept) begin
                rate_q <= cmd_rate;
            end
        end
    end

    rgb_fader_chan #(.WIDTH(WIDTH)) u_chan_r (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .step       (step),
        .cmd_target (cmd_r),
        .value      (r),
        .at_target  (at_r)
    );

    rgb_fader_chan #(.WIDTH(WIDTH)) u_chan_g (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .step       (step),
        .cmd_target (cmd_g),
        .value      (g),
        .at_target  (at_g)
    );

    rgb_fader_chan #(.WIDTH(WIDTH)) u_chan_b (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .step       (step),
        .cmd_target (cmd_b),
        .value      (b),
        .at_target  (at_b)
    );

    assign cmd_ready = (state_q == FADE_IDLE);
    assign busy      = (state_q == FADE_RUN);
    assign done      = done_q;

endmodule

// File: tb/tb_rgb_fader.sv
// Bench for rgb_fader: expected final colour and done cycle of each command are
// queued at send time and checked when the done pulse appears.
module tb_rgb_fader;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_r, cmd_g, cmd_b;
    logic [15:0] cmd_rate;
    logic [7:0]  r, g, b;
    logic        busy;
    logic        done;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         n_vec;
    int         n_err;
    logic [7:0] cur_r, cur_g, cur_b;

    rgb_fader #(.WIDTH(8), .RATE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_r     (cmd_r),
        .cmd_g     (cmd_g),
        .cmd_b     (cmd_b),
        .cmd_rate  (cmd_rate),
        .r         (r),
        .g         (g),
        .b         (b),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int absdiff(input logic [7:0] a, input logic [7:0] c);
        return (a > c) ? int'(a) - int'(c) : int'(c) - int'(a);
    endfunction

    // Queue expected result for a command accepted at edge acc; returns its done cycle.
    function automatic int push_exp(input logic [7:0] tr, input logic [7:0] tg,
                                    input logic [7:0] tb_, input logic [15:0] rate,
                                    input int acc);
        int   d;
        exp_t e;
        d = absdiff(cur_r, tr);
        if (absdiff(cur_g, tg) > d) d = absdiff(cur_g, tg);
        if (absdiff(cur_b, tb_) > d) d = absdiff(cur_b, tb_);
        e.r   = tr;
        e.g   = tg;
        e.b   = tb_;
        e.cyc = acc + d * (int'(rate) + 1) + 1;
        sb.push_back(e);
        cur_r = tr;
        cur_g = tg;
        cur_b = tb_;
        return e.cyc;
    endfunction

    // Called at a negedge with the fader idle; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] tr, input logic [7:0] tg, input logic [7:0] tb_,
                        input logic [15:0] rate, input bit hold, output int done_cyc);
        check("ready_at_send", {31'd0, cmd_ready}, 32'd1);
        cmd_r     = tr;
        cmd_g     = tg;
        cmd_b     = tb_;
        cmd_rate  = rate;
        cmd_valid = 1'b1;
        done_cyc  = push_exp(tr, tg, tb_, rate, cyc + 1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_in_budget", {31'd0, n < 5000}, 32'd1);
    endtask

    task automatic check_rgb(input string tag, input logic [7:0] er, input logic [7:0] eg,
                             input logic [7:0] eb);
        check(tag, {8'd0, r, g, b}, {8'd0, er, eg, eb});
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check_rgb("done_rgb", e.r, e.g, e.b);
            end
        end
    end

    initial begin
        int dc_a, dc_b, acc;
        n_vec     = 0;
        n_err     = 0;
        cur_r     = '0;
        cur_g     = '0;
        cur_b     = '0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_r     = '0;
        cmd_g     = '0;
        cmd_b     = '0;
        cmd_rate  = '0;

        // Reset state, then release and hold
        repeat (3) @(negedge clk);
        check_rgb("rst_rgb", 8'd0, 8'd0, 8'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_rgb("post_rst_rgb", 8'd0, 8'd0, 8'd0);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Rate 0 ramp with a second command held on cmd_valid
        send(8'd255, 8'd128, 8'd0, 16'd0, 1'b1, dc_a);
        acc      = cyc;
        cmd_r    = 8'd10;
        cmd_g    = 8'd20;
        cmd_b    = 8'd30;
        cmd_rate = 16'd1;
        dc_b     = push_exp(8'd10, 8'd20, 8'd30, 16'd1, dc_a + 1);
        check("fade_busy", {31'd0, busy}, 32'd1);
        check("fade_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (127) @(negedge clk);
        check("g_127", {24'd0, g}, 32'd127);
        @(negedge clk);
        check("g_128", {24'd0, g}, 32'd128);
        check("r_128", {24'd0, r}, 32'd128);
        check("held_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (127) @(negedge clk);
        check("r_255", {24'd0, r}, 32'd255);
        check("busy_255", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("done_256", {31'd0, done}, 32'd1);
        check("ready_256", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("held_accept_busy", {31'd0, busy}, 32'd1);
        check("held_accept_ready", {31'd0, cmd_ready}, 32'd0);
        check("held_accept_cyc", cyc, acc + 257);
        cmd_valid = 1'b0;
        wait_idle();
        check("second_done_cyc", cyc, dc_b);

        // Back to (255,128,0), then rate 3 fade to (0,128,10)
        send(8'd255, 8'd128, 8'd0, 16'd0, 1'b0, dc_a);
        wait_idle();
        send(8'd0, 8'd128, 8'd10, 16'd3, 1'b0, dc_a);
        check("r3_start", {24'd0, r}, 32'd255);
        repeat (3) @(negedge clk);
        check("r3_c3", {24'd0, r}, 32'd255);
        @(negedge clk);
        check("r3_c4", {24'd0, r}, 32'd254);
        repeat (36) @(negedge clk);
        check_rgb("r3_c40", 8'd245, 8'd128, 8'd10);
        wait_idle();
        check("r3_done_cyc", cyc, dc_a);

        // Target equal to current colour
        send(8'd0, 8'd128, 8'd10, 16'd100, 1'b0, dc_a);
        check("eq_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("eq_done", {31'd0, done}, 32'd1);
        check("eq_busy_off", {31'd0, busy}, 32'd0);
        check_rgb("eq_rgb", 8'd0, 8'd128, 8'd10);

        // Asynchronous reset mid-fade
        @(negedge clk);
        send(8'd255, 8'd128, 8'd0, 16'd0, 1'b0, dc_a);
        wait_idle();
        send(8'd0, 8'd128, 8'd10, 16'd3, 1'b0, dc_a);
        repeat (49) @(negedge clk);
        check("pre_rst_r", {24'd0, r}, 32'd243);
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.delete();
        cur_r = '0;
        cur_g = '0;
        cur_b = '0;
        #1;
        check_rgb("async_rst_rgb", 8'd0, 8'd0, 8'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
            check("idle_after_rst", {31'd0, busy}, 32'd0);
        end
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
